// File: rtl/pdp8_trace_buffer_pkg.sv
// Shared PDP-8 trace definitions: entry layout, entry types, FSM states.
package pdp8_trace_buffer_pkg;

  localparam int unsigned TRACE_ENTRY_W = 28;
  localparam int unsigned WORD_W        = 12;
  localparam int unsigned DROP_W        = 16;

  typedef enum logic [1:0] {
    TT_IF = 2'd0,
    TT_DR = 2'd1,
    TT_DW = 2'd2,
    TT_BR = 2'd3
  } trace_type_t;

  typedef struct packed {
    trace_type_t         ttype;
    logic [1:0]          flags;
    logic [WORD_W-1:0]   addr;
    logic [WORD_W-1:0]   data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FROZEN  = 2'd2
  } trace_state_t;

  // Saturating add of a small increment onto the drop counter.
  function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] a,
                                                     input logic [1:0]        b);
    logic [DROP_W:0] sum;
    sum = {1'b0, a} + (DROP_W+1)'(b);
    return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/pdp8_trace_buffer_ram.sv
// Trace storage: synchronous write port, asynchronous read port, not reset.
module trace_fifo_ram
  import pdp8_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  trace_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output trace_entry_t             rdata
);

  trace_entry_t mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pdp8_trace_buffer.sv
// PDP-8 bus/branch trace buffer: capture FSM, branch pending slot, FIFO control.
// DEPTH must be a power of two in 4..4096.
module pdp8_trace_buffer
  import pdp8_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter bit          OVERWRITE = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       mem_finished,
  input  logic                       read_enable,
  input  logic                       write_enable,
  input  logic                       read_type,
  input  logic [11:0]                address,
  input  logic [11:0]                read_data,
  input  logic [11:0]                write_data,
  input  logic                       br_valid,
  input  logic [11:0]                br_pc,
  input  logic [11:0]                br_target,
  input  logic                       br_cond,
  input  logic                       br_taken,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TRACE_ENTRY_W-1:0]   out_entry,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                dropped,
  output logic [1:0]                 state
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  trace_state_t        state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DROP_W-1:0]   dropped_q, dropped_d;
  logic                out_valid_q, out_valid_d;
  logic                pend_vld_q, pend_vld_d;
  trace_entry_t        pend_q, pend_d;

  logic                cap_en, mem_ev, mem_noop, br_ev;
  logic                wr_req, push, adv_rd, pop, full;
  logic                br_drop, wr_drop;
  trace_entry_t        mem_entry, br_entry, wr_entry, rd_entry;

  // Entry formation, pending-slot arbitration, FIFO accounting and FSM.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pend_vld_d  = pend_vld_q;
    pend_d      = pend_q;
    wr_req      = 1'b0;
    wr_entry    = pend_q;
    br_drop     = 1'b0;
    wr_drop     = 1'b0;
    push        = 1'b0;

    cap_en   = (state_q == ST_CAPTURE) && run;
    mem_ev   = cap_en && mem_finished && (read_enable || write_enable);
    mem_noop = cap_en && mem_finished && !read_enable && !write_enable;
    br_ev    = cap_en && br_valid;

    mem_entry.ttype = write_enable ? TT_DW : (read_type ? TT_IF : TT_DR);
    mem_entry.flags = 2'b00;
    mem_entry.addr  = address;
    mem_entry.data  = write_enable ? write_data : read_data;

    br_entry.ttype  = TT_BR;
    br_entry.flags  = {br_cond, br_taken};
    br_entry.addr   = br_pc;
    br_entry.data   = br_target;

    // One FIFO write per cycle: memory event, then pending branch, then new branch.
    if (mem_ev) begin
      wr_req   = 1'b1;
      wr_entry = mem_entry;
      if (br_ev) begin
        if (pend_vld_q) begin
          br_drop = 1'b1;
        end else begin
          pend_vld_d = 1'b1;
          pend_d     = br_entry;
        end
      end
    end else if (pend_vld_q) begin
      wr_req     = 1'b1;
      wr_entry   = pend_q;
      pend_vld_d = 1'b0;
      br_drop    = br_ev;
    end else if (br_ev) begin
      wr_req   = 1'b1;
      wr_entry = br_entry;
    end

    full   = (count_q == CNT_W'(DEPTH));
    pop    = out_valid_q && out_ready;
    adv_rd = pop;

    // A full buffer accepts a write only alongside a pop, or by evicting the oldest.
    if (wr_req) begin
      if (!full || pop) begin
        push = 1'b1;
      end else if (OVERWRITE) begin
        push    = 1'b1;
        adv_rd  = 1'b1;
        wr_drop = 1'b1;
      end else begin
        wr_drop = 1'b1;
      end
    end

    if (push)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (adv_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !adv_rd) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && adv_rd) begin
      count_d = count_q - CNT_W'(1);
    end

    dropped_d   = sat_add_drop(dropped_q, 2'(mem_noop) + 2'(br_drop) + 2'(wr_drop));
    out_valid_d = (count_d != '0);

    unique case (state_q)
      ST_IDLE:    if (run) state_d = ST_CAPTURE;
      ST_CAPTURE: if (!run) state_d = ST_FROZEN;
      ST_FROZEN: begin
        if (run) begin
          state_d = ST_CAPTURE;
        end else if ((count_q == '0) && !pend_vld_q) begin
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset overrides any capture or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dropped_q   <= '0;
      out_valid_q <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dropped_q   <= dropped_d;
      out_valid_q <= out_valid_d;
      pend_vld_q  <= pend_vld_d;
      pend_q      <= pend_d;
    end
  end

  trace_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push && !reset),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign out_valid = out_valid_q;
  assign out_entry = out_valid_q ? rd_entry : '0;
  assign count     = count_q;
  assign dropped   = dropped_q;
  assign state     = 2'(state_q);

endmodule

// File: doc/pdp8_trace_buffer.md
PDP8_TRACE_BUFFER -- requirements
Module: pdp8_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 64: number of trace entries; SHALL be a power of two, 4 to 4096.
REQ-002 Parameter OVERWRITE, default 0: 0 = stop capturing when full; 1 = discard the oldest entry when full.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 run  in  1  high while the CPU program is running.
REQ-006 mem_finished  in  1  one-cycle pulse marking a completed bus transaction.
REQ-007 read_enable, write_enable, read_type  in  1 each  bus qualifiers; read_type 1 = instruction fetch, 0 = data read.
REQ-008 address, read_data, write_data  in  12 each  bus address and data.
REQ-009 br_valid  in  1  one-cycle pulse marking a branch event.
REQ-010 br_pc, br_target  in  12 each  branch source and target.
REQ-011 br_cond, br_taken  in  1 each  conditional flag and taken flag.
REQ-012 out_valid  out  1  an entry is available to drain.
REQ-013 out_ready  in  1  the consumer accepts the entry.
REQ-014 out_entry  out  28  {type[1:0], flags[1:0], addr[11:0], data[11:0]}.
REQ-015 count  out  log2(DEPTH)+1  number of stored entries.
REQ-016 dropped  out  16  number of lost events, saturating at 16'hFFFF.
REQ-017 state  out  2  current FSM state.

Function
REQ-018 Entry type encoding SHALL be IF=0, DR=1, DW=2, BR=3.
REQ-019 Memory entries SHALL set addr = address, flags = 0, and data = read_data for reads or write_data for writes.
REQ-020 Branch entries SHALL set addr = br_pc, data = br_target, flags = {br_cond, br_taken}.
REQ-021 The FSM SHALL have three states: IDLE=0, CAPTURE=1, FROZEN=2.
REQ-022 FSM transitions:
- IDLE -> CAPTURE on a cycle with run=1.
- CAPTURE -> FROZEN on a cycle with run=0.
- FROZEN -> IDLE once the buffer is empty and run=0.
- FROZEN -> CAPTURE on run=1; stored entries are kept.
REQ-023 Events SHALL be captured only in CAPTURE, and only when the qualifying run=1 is in the same cycle.
REQ-024 A mem_finished pulse with neither read_enable nor write_enable asserted SHALL increment dropped and SHALL NOT create an entry.
REQ-025 A qualified event SHALL be written at the rising edge of the same cycle; it SHALL appear on out_entry one cycle later at the earliest.
REQ-026 When a memory event and a branch event occur in the same cycle:
- the memory entry is written first;
- the branch is held in a one-entry pending register and written the next cycle, ahead of any new branch.
REQ-027 A branch arriving while the pending register is occupied SHALL be dropped and SHALL increment dropped.
REQ-028 out_valid SHALL equal (count != 0); out_entry SHALL show the oldest entry; a pop SHALL occur when out_valid and out_ready are both high.
REQ-029 Full with OVERWRITE=0: new events SHALL be dropped and SHALL increment dropped.
REQ-030 Full with OVERWRITE=1: a write SHALL also advance the read pointer, count stays DEPTH, and dropped increments.
REQ-031 A simultaneous pop and push when full SHALL overwrite nothing: count is unchanged and dropped is unchanged.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH.
REQ-033 Draining SHALL be allowed in every state.

Reset
REQ-034 reset SHALL take effect at the next clk edge and SHALL produce: state=IDLE, pointers=0, count=0, dropped=0, pending empty, out_valid=0, out_entry=0.
REQ-035 reset SHALL win over any simultaneous capture or pop.
REQ-036 A reset during CAPTURE SHALL discard all stored entries.
REQ-037 Storage contents need not be cleared by reset.

Structure
REQ-038 The shared CPU definitions package SHALL hold:
- the trace_type_t enum;
- the trace_entry_t packed struct;
- the trace_state_t enum;
- the TRACE_ENTRY_W=28 constant.
REQ-039 Storage SHALL be one sub-module, trace_fifo_ram, with a synchronous write port and an asynchronous read port, DEPTH x 28.
REQ-040 The FSM, pending register and counters SHALL be in pdp8_trace_buffer.

Verification
REQ-041 run=1; IF at 0200 with read_data 7200; DW at 0050 with write_data 1234 -> drained entries in order {0,0,0200,7200} and {2,0,0050,1234}.
REQ-042 mem_finished DR plus br_valid (pc 0203, target 0205, cond=1, taken=1) in the same cycle -> entries in order DR, then {3,3,0203,0205}; dropped=0.
REQ-043 DEPTH=4, OVERWRITE=0, out_ready=0, six IF events -> count=4, dropped=2, first four events retained.
REQ-044 DEPTH=4, OVERWRITE=1, six IF events at addresses 1-6 -> drained addresses 3,4,5,6; dropped=2.
REQ-045 Fill 3 entries, drop run to 0, drain all -> state goes CAPTURE, FROZEN, IDLE; events arriving in FROZEN are not captured.
REQ-046 reset asserted mid-capture with count=3 -> next cycle count=0, out_valid=0, state=IDLE, dropped=0.
